// File: rtl/icetap_pkg.sv
// icetap_pkg: shared definitions for the icetap scan-chain initiator and
// the host-side mask builders.
//   - CHAIN_* : scan chain identifiers carried on req_chain
//   - state_t : scan controller FSM encoding
//   - TRIGGER_*: per-channel trigger mask codes
//   - chain_valid / chain_has_return: chain property helpers
package icetap_pkg;

  localparam logic [2:0] CHAIN_CMD          = 3'd0;
  localparam logic [2:0] CHAIN_STATUS       = 3'd1;
  localparam logic [2:0] CHAIN_STORE_MASK   = 3'd2;
  localparam logic [2:0] CHAIN_TRIGGER_MASK = 3'd3;
  localparam logic [2:0] CHAIN_DATA         = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_UPD  = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_POST_UPD = 3'd4,
    ST_RSP      = 3'd5
  } state_t;

  // Two bits per analyser channel in the trigger_mask chain.
  localparam logic [1:0] TRIGGER_IGNORE  = 2'b00;
  localparam logic [1:0] TRIGGER_RISING  = 2'b01;
  localparam logic [1:0] TRIGGER_FALLING = 2'b10;
  localparam logic [1:0] TRIGGER_EITHER  = 2'b11;

  function automatic logic chain_valid(input logic [2:0] chain);
    return chain <= CHAIN_DATA;
  endfunction

  // Chains that return data also have an update port that loads them
  // before shifting (capture-then-shift).
  function automatic logic chain_has_return(input logic [2:0] chain);
    return (chain == CHAIN_STATUS) || (chain == CHAIN_DATA);
  endfunction

endpackage

// File: rtl/icetap_scan_ctrl_if.sv
// icetap_scan_ctrl_if: request/response channel between the host transport
// and the scan controller.
//   req_valid/req_ready handshake with req_chain, req_nr_bits, req_update,
//   req_wr_data; rsp_valid pulse with rsp_err and rsp_rd_data.
//   master = host side, slave = scan controller.
interface icetap_scan_ctrl_if #(
  parameter int MAX_BITS = 64
);
  localparam int CNT_BITS = $clog2(MAX_BITS + 1);

  logic                req_valid;
  logic                req_ready;
  logic [2:0]          req_chain;
  logic [CNT_BITS-1:0] req_nr_bits;
  logic                req_update;
  logic [MAX_BITS-1:0] req_wr_data;
  logic                rsp_valid;
  logic                rsp_err;
  logic [MAX_BITS-1:0] rsp_rd_data;

  modport master (
    output req_valid, req_chain, req_nr_bits, req_update, req_wr_data,
    input  req_ready, rsp_valid, rsp_err, rsp_rd_data
  );

  modport slave (
    input  req_valid, req_chain, req_nr_bits, req_update, req_wr_data,
    output req_ready, rsp_valid, rsp_err, rsp_rd_data
  );
endinterface

// File: rtl/icetap_scan_ctrl.sv
// icetap_scan_ctrl: scan-chain initiator for the icetap analyser core.
// Takes one parallel request at a time, drives the selected chain's
// shift_ena/shift_data/shift_update strobes and returns the bits shifted out.
//   scan_clk, scan_reset : clock, asynchronous active-high reset
//   bus (slave)          : request/response channel
//   cmd_*, status_*, store_mask_*, trigger_mask_*, data_* : scan strobes;
//   status_shift_data / data_shift_data are the chains' return bits.
module icetap_scan_ctrl
  import icetap_pkg::*;
#(
  parameter int MAX_BITS = 64
) (
  input  logic               scan_clk,
  input  logic               scan_reset,
  icetap_scan_ctrl_if.slave  bus,
  output logic               cmd_shift_ena,
  output logic               cmd_shift_data,
  output logic               cmd_shift_update,
  output logic               status_shift_update,
  output logic               status_shift_ena,
  input  logic               status_shift_data,
  output logic               store_mask_shift_ena,
  output logic               store_mask_shift_data,
  output logic               trigger_mask_shift_ena,
  output logic               trigger_mask_shift_data,
  output logic               data_shift_update,
  output logic               data_shift_ena,
  input  logic               data_shift_data
);

  localparam int CNT_BITS = $clog2(MAX_BITS + 1);
  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_BITS);

  state_t              state_reg, state_next;
  logic [2:0]          chain_reg;
  logic                post_reg;
  logic                err_reg;
  // Shift cycles not yet scheduled onto the registered strobes.
  logic [CNT_BITS-1:0] cnt_reg;
  logic [MAX_BITS-1:0] wr_reg;
  logic [MAX_BITS-1:0] rd_reg;

  logic                accept;
  logic                in_idle;
  logic [2:0]          chain_src;
  logic                err_src;
  logic [CNT_BITS-1:0] n_eff;
  logic [CNT_BITS-1:0] cnt_src;
  logic [CNT_BITS-1:0] bit_idx;
  logic [MAX_BITS-1:0] wr_src;
  logic                shift_bit;
  logic                ret_bit;

  logic cmd_ena_reg, cmd_data_reg, cmd_upd_reg, cmd_ena_next, cmd_data_next, cmd_upd_next;
  logic st_ena_reg, st_upd_reg, st_ena_next, st_upd_next;
  logic sm_ena_reg, sm_data_reg, sm_ena_next, sm_data_next;
  logic tm_ena_reg, tm_data_reg, tm_ena_next, tm_data_next;
  logic dt_ena_reg, dt_upd_reg, dt_ena_next, dt_upd_next;
  logic rsp_valid_reg, rsp_err_reg, rsp_valid_next, rsp_err_next;

  // Strobes are registered from state_next, so while accepting the request
  // fields must come straight from the bus rather than the latched copies.
  assign in_idle   = (state_reg == ST_IDLE);
  assign accept    = in_idle && bus.req_valid;
  assign n_eff     = (bus.req_nr_bits > MAX_CNT) ? MAX_CNT : bus.req_nr_bits;
  assign chain_src = in_idle ? bus.req_chain : chain_reg;
  assign err_src   = in_idle ? !chain_valid(bus.req_chain) : err_reg;
  assign cnt_src   = in_idle ? n_eff : cnt_reg;
  assign wr_src    = in_idle ? bus.req_wr_data : wr_reg;
  assign bit_idx   = cnt_src - CNT_BITS'(1);
  // MSB-first: the next scheduled bit is wr[remaining-1].
  assign shift_bit = |(wr_src & (MAX_BITS'(1) << bit_idx));
  assign ret_bit   = (chain_reg == CHAIN_STATUS) ? status_shift_data :
                     (chain_reg == CHAIN_DATA)   ? data_shift_data   : 1'b0;

  always_ff @(posedge scan_clk or posedge scan_reset) begin
    if (scan_reset) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (!chain_valid(bus.req_chain))                           state_next = ST_RSP;
          else if (bus.req_update && chain_has_return(bus.req_chain)) state_next = ST_PRE_UPD;
          else if (n_eff != '0)                                      state_next = ST_SHIFT;
          else if (bus.req_update && bus.req_chain == CHAIN_CMD)      state_next = ST_POST_UPD;
          else                                                       state_next = ST_RSP;
        end
      end
      ST_PRE_UPD:  state_next = ST_SETTLE;
      ST_SETTLE:   state_next = (cnt_reg != '0) ? ST_SHIFT : ST_RSP;
      ST_SHIFT: begin
        if (cnt_reg != '0) state_next = ST_SHIFT;
        else if (post_reg) state_next = ST_POST_UPD;
        else               state_next = ST_RSP;
      end
      ST_POST_UPD: state_next = ST_RSP;
      ST_RSP:      state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge scan_clk or posedge scan_reset) begin
    if (scan_reset) begin
      chain_reg <= '0;
      post_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      wr_reg    <= '0;
      rd_reg    <= '0;
    end else begin
      if (accept) begin
        chain_reg <= bus.req_chain;
        post_reg  <= bus.req_update && (bus.req_chain == CHAIN_CMD);
        err_reg   <= !chain_valid(bus.req_chain);
        wr_reg    <= bus.req_wr_data;
        rd_reg    <= '0;
        cnt_reg   <= n_eff;
      end
      if (state_next == ST_SHIFT) cnt_reg <= bit_idx;
      // Return bit is valid during the shift cycle itself.
      if (state_reg == ST_SHIFT) rd_reg <= {rd_reg[MAX_BITS-2:0], ret_bit};
    end
  end

  always_comb begin
    cmd_ena_next   = (state_next == ST_SHIFT) && (chain_src == CHAIN_CMD);
    cmd_data_next  = cmd_ena_next && shift_bit;
    cmd_upd_next   = (state_next == ST_POST_UPD);
    st_ena_next    = (state_next == ST_SHIFT) && (chain_src == CHAIN_STATUS);
    st_upd_next    = (state_next == ST_PRE_UPD) && (chain_src == CHAIN_STATUS);
    sm_ena_next    = (state_next == ST_SHIFT) && (chain_src == CHAIN_STORE_MASK);
    sm_data_next   = sm_ena_next && shift_bit;
    tm_ena_next    = (state_next == ST_SHIFT) && (chain_src == CHAIN_TRIGGER_MASK);
    tm_data_next   = tm_ena_next && shift_bit;
    dt_ena_next    = (state_next == ST_SHIFT) && (chain_src == CHAIN_DATA);
    dt_upd_next    = (state_next == ST_PRE_UPD) && (chain_src == CHAIN_DATA);
    rsp_valid_next = (state_next == ST_RSP);
    rsp_err_next   = rsp_valid_next && err_src;
  end

  always_ff @(posedge scan_clk or posedge scan_reset) begin
    if (scan_reset) begin
      {cmd_ena_reg, cmd_data_reg, cmd_upd_reg} <= '0;
      {st_ena_reg, st_upd_reg}                 <= '0;
      {sm_ena_reg, sm_data_reg}                <= '0;
      {tm_ena_reg, tm_data_reg}                <= '0;
      {dt_ena_reg, dt_upd_reg}                 <= '0;
      {rsp_valid_reg, rsp_err_reg}             <= '0;
    end else begin
      {cmd_ena_reg, cmd_data_reg, cmd_upd_reg} <= {cmd_ena_next, cmd_data_next, cmd_upd_next};
      {st_ena_reg, st_upd_reg}                 <= {st_ena_next, st_upd_next};
      {sm_ena_reg, sm_data_reg}                <= {sm_ena_next, sm_data_next};
      {tm_ena_reg, tm_data_reg}                <= {tm_ena_next, tm_data_next};
      {dt_ena_reg, dt_upd_reg}                 <= {dt_ena_next, dt_upd_next};
      {rsp_valid_reg, rsp_err_reg}             <= {rsp_valid_next, rsp_err_next};
    end
  end

  assign bus.req_ready            = in_idle;
  assign bus.rsp_valid            = rsp_valid_reg;
  assign bus.rsp_err              = rsp_err_reg;
  assign bus.rsp_rd_data          = rd_reg;
  assign cmd_shift_ena            = cmd_ena_reg;
  assign cmd_shift_data           = cmd_data_reg;
  assign cmd_shift_update         = cmd_upd_reg;
  assign status_shift_ena         = st_ena_reg;
  assign status_shift_update      = st_upd_reg;
  assign store_mask_shift_ena     = sm_ena_reg;
  assign store_mask_shift_data    = sm_data_reg;
  assign trigger_mask_shift_ena   = tm_ena_reg;
  assign trigger_mask_shift_data  = tm_data_reg;
  assign data_shift_ena           = dt_ena_reg;
  assign data_shift_update        = dt_upd_reg;

endmodule

// File: tb/tb_icetap_scan_ctrl.sv
// tb_icetap_scan_ctrl: scoreboard bench for icetap_scan_ctrl. Directed
// requests push their hand-computed response, strobe counts and target
// register contents into a queue; a negedge monitor pops and compares on
// every rsp_valid. Small target models emulate the status and data chains.
module tb_icetap_scan_ctrl;
  import icetap_pkg::*;

  localparam int MAX_BITS = 64;
  localparam int CNT_BITS = $clog2(MAX_BITS + 1);

  logic scan_clk = 1'b0;
  logic scan_reset;
  always #5 scan_clk = ~scan_clk;

  icetap_scan_ctrl_if #(.MAX_BITS(MAX_BITS)) bus ();

  logic cmd_e, cmd_d, cmd_u, st_u, st_e, st_d, sm_e, sm_d, tm_e, tm_d, dt_u, dt_e, dt_d;

  icetap_scan_ctrl #(.MAX_BITS(MAX_BITS)) dut (
    .scan_clk                (scan_clk),
    .scan_reset              (scan_reset),
    .bus                     (bus),
    .cmd_shift_ena           (cmd_e),
    .cmd_shift_data          (cmd_d),
    .cmd_shift_update        (cmd_u),
    .status_shift_update     (st_u),
    .status_shift_ena        (st_e),
    .status_shift_data       (st_d),
    .store_mask_shift_ena    (sm_e),
    .store_mask_shift_data   (sm_d),
    .trigger_mask_shift_ena  (tm_e),
    .trigger_mask_shift_data (tm_d),
    .data_shift_update       (dt_u),
    .data_shift_ena          (dt_e),
    .data_shift_data         (dt_d)
  );

  // Target chains with a return port: load a fixed pattern on update,
  // present their MSB and shift left on each enabled cycle.
  logic [7:0] st_sr = 8'h00;
  logic [7:0] dt_sr = 8'h00;
  always @(posedge scan_clk) begin
    if (st_u)      st_sr <= 8'hA5;
    else if (st_e) st_sr <= {st_sr[6:0], 1'b0};
    if (dt_u)      dt_sr <= 8'h3C;
    else if (dt_e) dt_sr <= {dt_sr[6:0], 1'b0};
  end
  assign st_d = st_sr[7];
  assign dt_d = dt_sr[7];

  wire [10:0] strobes = {cmd_e, cmd_d, cmd_u, st_u, st_e, sm_e, sm_d, tm_e, tm_d, dt_u, dt_e};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] rd;
    logic        err;
    int          lat;
    int          chain;
    int          ena;
    int          cu;
    int          su;
    int          du;
    logic        ct;
    logic [63:0] tgt;
  } exp_t;

  exp_t sb_q[$];

  initial forever begin
    @(posedge scan_clk);
    cyc++;
  end

  // Monitor: strobe accounting, protocol rules and response scoreboard.
  initial begin
    exp_t        e;
    int          acc_cyc;
    int          ena_cnt[5];
    int          cu_c, su_c, du_c, tot, sel;
    logic [63:0] cmd_t, sm_t, tm_t, tgt;
    acc_cyc = 0; cu_c = 0; su_c = 0; du_c = 0;
    cmd_t = '0; sm_t = '0; tm_t = '0;
    for (int i = 0; i < 5; i++) ena_cnt[i] = 0;
    forever begin
      @(negedge scan_clk);
      if (!scan_reset) begin
        if (bus.req_valid && bus.req_ready) begin
          acc_cyc = cyc;
          for (int i = 0; i < 5; i++) ena_cnt[i] = 0;
          cu_c = 0; su_c = 0; du_c = 0;
          cmd_t = '0; sm_t = '0; tm_t = '0;
        end
        if (cmd_e) begin ena_cnt[0]++; cmd_t = {cmd_t[62:0], cmd_d}; end
        if (st_e)  ena_cnt[1]++;
        if (sm_e)  begin ena_cnt[2]++; sm_t = {sm_t[62:0], sm_d}; end
        if (tm_e)  begin ena_cnt[3]++; tm_t = {tm_t[62:0], tm_d}; end
        if (dt_e)  ena_cnt[4]++;
        if (cmd_u) cu_c++;
        if (st_u)  su_c++;
        if (dt_u)  du_c++;
        chk("one_chain", 64'($countones({cmd_e | cmd_d | cmd_u, st_u | st_e, sm_e | sm_d,
                                          tm_e | tm_d, dt_u | dt_e}) <= 1), 64'(1));
        chk("data_gated", 64'((cmd_d & ~cmd_e) | (sm_d & ~sm_e) | (tm_d & ~tm_e)), 64'(0));
        if (bus.rsp_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_rsp", 64'(1), 64'(0));
          end else begin
            e   = sb_q.pop_front();
            tot = ena_cnt[0] + ena_cnt[1] + ena_cnt[2] + ena_cnt[3] + ena_cnt[4];
            sel = (e.chain >= 0 && e.chain < 5) ? ena_cnt[e.chain] : 0;
            $display("rsp %s: rd=%h err=%0d lat=%0d ena=%0d upd=%0d/%0d/%0d",
                     e.name, bus.rsp_rd_data, bus.rsp_err, cyc - acc_cyc, tot, cu_c, su_c, du_c);
            chk({e.name, "_rd"},      bus.rsp_rd_data,      e.rd);
            chk({e.name, "_err"},     64'(bus.rsp_err),     64'(e.err));
            chk({e.name, "_lat"},     64'(cyc - acc_cyc),   64'(e.lat));
            chk({e.name, "_ena_sel"}, 64'(sel),             64'(e.ena));
            chk({e.name, "_ena_all"}, 64'(tot),             64'(e.ena));
            chk({e.name, "_cmd_upd"}, 64'(cu_c),            64'(e.cu));
            chk({e.name, "_st_upd"},  64'(su_c),            64'(e.su));
            chk({e.name, "_dt_upd"},  64'(du_c),            64'(e.du));
            if (e.ct) begin
              tgt = (e.chain == 0) ? cmd_t : (e.chain == 2) ? sm_t : tm_t;
              chk({e.name, "_target"}, tgt, e.tgt);
            end
          end
        end
      end
    end
  end

  task automatic send(input string name, input logic [2:0] chain, input int n,
                      input logic upd, input logic [63:0] wr, input bit push,
                      input logic [63:0] rd, input logic err, input int lat, input int ena,
                      input int cu, input int su, input int du, input logic ct,
                      input logic [63:0] tgt);
    exp_t e;
    int   t;
    t = 0;
    @(posedge scan_clk); #1;
    while (!bus.req_ready && t < 500) begin @(posedge scan_clk); #1; t++; end
    chk({name, "_ready"}, 64'(bus.req_ready), 64'(1));
    e.name = name; e.rd = rd; e.err = err; e.lat = lat; e.chain = int'(chain);
    e.ena = ena; e.cu = cu; e.su = su; e.du = du; e.ct = ct; e.tgt = tgt;
    if (push) sb_q.push_back(e);
    bus.req_chain   = chain;
    bus.req_nr_bits = CNT_BITS'(n);
    bus.req_update  = upd;
    bus.req_wr_data = wr;
    bus.req_valid   = 1'b1;
    @(posedge scan_clk); #1;
    bus.req_valid   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin @(posedge scan_clk); t++; end
    if (sb_q.size() != 0) begin
      chk({name, "_timeout"}, 64'(sb_q.size()), 64'(0));
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    scan_reset      = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_chain   = '0;
    bus.req_nr_bits = '0;
    bus.req_update  = 1'b0;
    bus.req_wr_data = '0;
    repeat (3) @(posedge scan_clk);
    @(negedge scan_clk);
    scan_reset = 1'b0;
    @(posedge scan_clk); #1;
    chk("reset_ready",   64'(bus.req_ready), 64'(1));
    chk("reset_rsp",     64'({bus.rsp_valid, bus.rsp_err}), 64'(0));
    chk("reset_rd",      bus.rsp_rd_data, 64'(0));
    chk("reset_strobes", 64'(strobes), 64'(0));

    //   name        chain               n    upd   wr                       push rd       err lat ena cu su du ct tgt
    send("cmd3",     CHAIN_CMD,          3,   1'b1, 64'hFFFF_FFFF_FFFF_FFF5, 1, 64'h0,   0, 5,  3,  1, 0, 0, 1, 64'h5);
    wait_done("cmd3");
    send("status8",  CHAIN_STATUS,       8,   1'b1, 64'h0,                   1, 64'hA5,  0, 11, 8,  0, 1, 0, 0, 64'h0);
    wait_done("status8");
    send("store64",  CHAIN_STORE_MASK,   64,  1'b1, 64'h0123_4567_89AB_CDEF, 1, 64'h0,   0, 65, 64, 0, 0, 0, 1, 64'h0123_4567_89AB_CDEF);
    wait_done("store64");
    send("data0",    CHAIN_DATA,         0,   1'b0, 64'hFFFF,                1, 64'h0,   0, 1,  0,  0, 0, 0, 0, 64'h0);
    wait_done("data0");
    send("bad6",     3'd6,               5,   1'b1, 64'h1F,                  1, 64'h0,   1, 1,  0,  0, 0, 0, 0, 64'h0);
    wait_done("bad6");
    send("trig100",  CHAIN_TRIGGER_MASK, 100, 1'b0, 64'hFEDC_BA98_7654_3210, 1, 64'h0,   0, 65, 64, 0, 0, 0, 1, 64'hFEDC_BA98_7654_3210);
    wait_done("trig100");
    send("cmd0upd",  CHAIN_CMD,          0,   1'b1, 64'h0,                   1, 64'h0,   0, 2,  0,  1, 0, 0, 0, 64'h0);
    wait_done("cmd0upd");
    send("status4",  CHAIN_STATUS,       4,   1'b1, 64'hF,                   1, 64'hA,   0, 7,  4,  0, 1, 0, 0, 64'h0);
    wait_done("status4");
    send("data8",    CHAIN_DATA,         8,   1'b1, 64'h0,                   1, 64'h3C,  0, 11, 8,  0, 0, 1, 0, 64'h0);
    wait_done("data8");
    send("store1",   CHAIN_STORE_MASK,   1,   1'b0, 64'h1,                   1, 64'h0,   0, 2,  1,  0, 0, 0, 1, 64'h1);
    wait_done("store1");

    // Request dropped by reset in its 4th shift cycle: no response expected.
    send("drop",     CHAIN_DATA,         8,   1'b0, 64'hAA,                  0, 64'h0,   0, 0,  0,  0, 0, 0, 0, 64'h0);
    repeat (3) @(posedge scan_clk);
    #1;
    chk("drop_shifting", 64'(dt_e), 64'(1));
    scan_reset = 1'b1;
    #1;
    chk("drop_strobes", 64'(strobes), 64'(0));
    chk("drop_rsp",     64'(bus.rsp_valid), 64'(0));
    repeat (2) @(negedge scan_clk);
    scan_reset = 1'b0;
    @(posedge scan_clk); #1;
    chk("post_reset_ready", 64'(bus.req_ready), 64'(1));
    chk("post_reset_rsp",   64'(bus.rsp_valid), 64'(0));
    send("recover",  CHAIN_DATA,         8,   1'b1, 64'h0,                   1, 64'h3C,  0, 11, 8,  0, 0, 1, 0, 64'h0);
    wait_done("recover");

    repeat (5) @(posedge scan_clk);
    chk("queue_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icetap_scan_ctrl.md
Name: icetap_scan_ctrl

Overview:
Scan-chain initiator for the icetap logic analyser. It drives the cmd, status, store_mask, trigger_mask and data scan chains that the analyser core exposes. It accepts one parallel request at a time (chain, bit count, write data, update flag), generates the shift_ena/shift_data/shift_update strobes, and returns the bits shifted out as a parallel response. It sits between a host transport (UART/SPI bridge) and the analyser's scan port, running entirely in the scan clock domain.

Parameters:
MAX_BITS, 64, maximum bits per request; also the width of req_wr_data and rsp_rd_data
CNT_BITS, $clog2(MAX_BITS+1), width of the bit counter and of req_nr_bits (derived; do not override)

Ports:
scan_clk  in  1  scan clock; all logic is on its rising edge
scan_reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_chain  in  3  0=cmd 1=status 2=store_mask 3=trigger_mask 4=data; 5-7 invalid
req_nr_bits  in  CNT_BITS  number of shift cycles
req_update  in  1  issue the chain's update strobe
req_wr_data  in  MAX_BITS  bits to shift in, right-justified
rsp_valid  out  1  one-cycle pulse when the request completes
rsp_err  out  1  qualified by rsp_valid; 1 = invalid chain
rsp_rd_data  out  MAX_BITS  captured bits, right-justified; qualified by rsp_valid
cmd_shift_ena, cmd_shift_data, cmd_shift_update  out  1 each
status_shift_update, status_shift_ena  out  1 each;  status_shift_data  in  1
store_mask_shift_ena, store_mask_shift_data  out  1 each
trigger_mask_shift_ena, trigger_mask_shift_data  out  1 each
data_shift_update, data_shift_ena  out  1 each;  data_shift_data  in  1

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE, counters and shift registers clear, every output is 0 except req_ready=1 after reset is released. A request in flight when reset asserts is dropped and produces no response.
- FSM states: IDLE, PRE_UPD, SETTLE, SHIFT, POST_UPD, RSP.
- IDLE: req_ready=1. On req_valid, latch the request and go to:
  - PRE_UPD if req_update=1 and chain is status or data;
  - otherwise SHIFT if the effective bit count N>0;
  - otherwise POST_UPD if req_update=1 and chain is cmd;
  - otherwise RSP.
- Effective count N = min(req_nr_bits, MAX_BITS).
- PRE_UPD (1 cycle): assert status_shift_update or data_shift_update. Next state is SETTLE.
- SETTLE (1 cycle): no strobes. This lets the target load its scan register. Next state is SHIFT if N>0, else RSP.
- SHIFT (exactly N cycles):
  - Assert the selected chain's shift_ena every cycle.
  - Drive shift_data MSB-first: cycle k (k=0..N-1) drives req_wr_data[N-1-k].
  - Sample the chain's return bit in the same cycle and shift it into the read register LSB-side (rd <= {rd, bit}). The first returned bit therefore ends at rsp_rd_data[N-1].
  - Chains without a return port (cmd, store_mask, trigger_mask) capture 0.
  - After the last cycle: POST_UPD if req_update=1 and chain is cmd, else RSP.
- POST_UPD (1 cycle): assert cmd_shift_update. Next state is RSP.
- RSP (1 cycle): rsp_valid=1 with rsp_rd_data and rsp_err. Next state is IDLE. The response is not back-pressured.
- req_update is ignored for store_mask and trigger_mask (those chains have no update port).
- Invalid chain (5-7): no strobes, skip straight to RSP with rsp_err=1 and rsp_rd_data=0.
- Strobe encoding: all strobes are registered outputs. At most one chain's strobes are active in any cycle. shift_data outputs are 0 whenever the matching shift_ena is 0.
- Timing: back-to-back requests leave at least one IDLE cycle between rsp_valid and the next acceptance. Latency from the acceptance edge to rsp_valid is N + 1 + 2·pre + post cycles.
- Unused high bits of rsp_rd_data are 0.

Decomposition:
- Shared package icetap_pkg holds:
  - chain ID constants CHAIN_CMD..CHAIN_DATA;
  - the FSM state encoding;
  - TRIGGER_* mask codes (reused by the host-side mask builders).
- No sub-module. The FSM, bit counter and the two shift registers fit naturally in one module.

Test Plan:
- cmd chain, N=3, wr=3'b101, update=1 -> cmd_shift_ena high 3 cycles with data 1,0,1; then cmd_shift_update high 1 cycle; rsp_valid 5 cycles after acceptance; rd=0; err=0.
- status chain, N=8, update=1, target model loads 8'hA5 on update -> status_shift_update 1 cycle, 1 SETTLE cycle, 8 shift cycles, rsp_rd_data=8'hA5, rsp_valid 11 cycles after acceptance.
- store_mask, N=MAX_BITS=64, wr=64'h0123_4567_89AB_CDEF, update=1 -> 64 shift cycles MSB-first; target register equals wr; no update strobe on any chain.
- data chain, update=0, N=0 -> no strobes at all; rsp_valid on the next cycle after acceptance; rd=0.
- req_chain=6 -> no strobes; rsp_err=1; rd=0. Then req_nr_bits=100 on trigger_mask -> exactly 64 shift cycles.
- scan_reset asserted mid-SHIFT (cycle 4 of 8) -> all strobes drop immediately and no rsp_valid. After release, req_ready=1 and a new request completes normally.
